// File: rtl/acc_mat_pkg.sv
// Shared definitions for the accumulator-matrix command loader:
// PIO command field layout, opcodes, status bit positions and FSM states.
package acc_mat_pkg;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_SET_PTR = 3'd1;
  localparam logic [2:0] OP_WRITE   = 3'd2;
  localparam logic [2:0] OP_CLEAR   = 3'd3;
  localparam logic [2:0] OP_COMMIT  = 3'd4;
  localparam logic [2:0] OP_CLR_ERR = 3'd5;

  localparam int TOG_BIT = 19;
  localparam int OP_MSB  = 18;
  localparam int OP_LSB  = 16;
  localparam int PAY_W   = 16;

  localparam int ST_ERR_OP      = 2;
  localparam int ST_ERR_RANGE   = 1;
  localparam int ST_ERR_OVERRUN = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/acc_mat_cmd_loader.sv
// Decodes toggle-flagged PIO command words into coefficient RAM writes,
// pointer updates, a full-matrix clear sequence and commit pulses.
//
// state | meaning
// IDLE  | decode one new command per cycle
// CLEAR | write zero to every coefficient address, new commands are overruns
module acc_mat_cmd_loader
  import acc_mat_pkg::*;
#(
  parameter  int ROWS = 4,
  parameter  int COLS = 4,
  localparam int AW   = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [19:0]   cmd_in,
  output logic          coef_we,
  output logic [AW-1:0] coef_addr,
  output logic [15:0]   coef_data,
  output logic          commit,
  output logic          busy,
  output logic [2:0]    status
);

  localparam logic [AW:0] N_COEF   = (AW + 1)'(ROWS * COLS);
  localparam logic [4:0]  ROWS_5   = 5'(ROWS);
  localparam logic [4:0]  COLS_5   = 5'(COLS);
  localparam logic [3:0]  ROW_LAST = 4'(ROWS - 1);
  localparam logic [3:0]  COL_LAST = 4'(COLS - 1);

  state_e               state_q, state_d;
  logic [19:0]          cmd_q;
  logic                 tog_q, tog_d;
  logic [3:0]           row_q, row_d;
  logic [3:0]           col_q, col_d;
  logic [AW:0]          clr_cnt_q, clr_cnt_d;
  logic                 coef_we_q, coef_we_d;
  logic [AW-1:0]        coef_addr_q, coef_addr_d;
  logic [15:0]          coef_data_q, coef_data_d;
  logic                 commit_q, commit_d;
  logic                 busy_q, busy_d;
  logic [2:0]           status_q, status_d;

  logic                 new_cmd;
  logic [2:0]           opcode;
  logic [PAY_W-1:0]     payload;
  logic [AW-1:0]        ptr_addr;
  logic                 clr_done;

  assign new_cmd  = cmd_q[TOG_BIT] ^ tog_q;
  assign opcode   = cmd_q[OP_MSB:OP_LSB];
  assign payload  = cmd_q[PAY_W-1:0];
  assign ptr_addr = AW'(32'(row_q) * 32'(COLS) + 32'(col_q));
  assign clr_done = (clr_cnt_q == N_COEF);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (new_cmd && opcode == OP_CLEAR) state_d = CLEAR;
      CLEAR:   if (clr_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tog_d       = new_cmd ? cmd_q[TOG_BIT] : tog_q;
    row_d       = row_q;
    col_d       = col_q;
    clr_cnt_d   = clr_cnt_q;
    coef_we_d   = 1'b0;
    coef_addr_d = coef_addr_q;
    coef_data_d = coef_data_q;
    commit_d    = 1'b0;
    busy_d      = busy_q;
    status_d    = status_q;
    case (state_q)
      IDLE: begin
        if (new_cmd) begin
          case (opcode)
            OP_NOP: ;
            OP_SET_PTR: begin
              if ({1'b0, payload[7:4]} >= ROWS_5 || {1'b0, payload[3:0]} >= COLS_5) begin
                status_d[ST_ERR_RANGE] = 1'b1;
              end else begin
                row_d = payload[7:4];
                col_d = payload[3:0];
              end
            end
            OP_WRITE: begin
              coef_we_d   = 1'b1;
              coef_addr_d = ptr_addr;
              coef_data_d = payload;
              if (col_q == COL_LAST) begin
                col_d = 4'd0;
                row_d = (row_q == ROW_LAST) ? 4'd0 : row_q + 4'd1;
              end else begin
                col_d = col_q + 4'd1;
              end
            end
            // The first clear write goes out with the same edge that raises busy.
            OP_CLEAR: begin
              coef_we_d   = 1'b1;
              coef_addr_d = '0;
              coef_data_d = '0;
              clr_cnt_d   = (AW + 1)'(1);
              busy_d      = 1'b1;
            end
            OP_COMMIT:  commit_d = 1'b1;
            OP_CLR_ERR: status_d = 3'b000;
            default:    status_d[ST_ERR_OP] = 1'b1;
          endcase
        end
      end
      CLEAR: begin
        if (new_cmd) status_d[ST_ERR_OVERRUN] = 1'b1;
        if (clr_done) begin
          busy_d = 1'b0;
          row_d  = 4'd0;
          col_d  = 4'd0;
        end else begin
          coef_we_d   = 1'b1;
          coef_addr_d = clr_cnt_q[AW-1:0];
          coef_data_d = '0;
          clr_cnt_d   = clr_cnt_q + (AW + 1)'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q       <= '0;
      tog_q       <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      clr_cnt_q   <= '0;
      coef_we_q   <= 1'b0;
      coef_addr_q <= '0;
      coef_data_q <= '0;
      commit_q    <= 1'b0;
      busy_q      <= 1'b0;
      status_q    <= '0;
    end else begin
      cmd_q       <= cmd_in;
      tog_q       <= tog_d;
      row_q       <= row_d;
      col_q       <= col_d;
      clr_cnt_q   <= clr_cnt_d;
      coef_we_q   <= coef_we_d;
      coef_addr_q <= coef_addr_d;
      coef_data_q <= coef_data_d;
      commit_q    <= commit_d;
      busy_q      <= busy_d;
      status_q    <= status_d;
    end
  end

  assign coef_we   = coef_we_q;
  assign coef_addr = coef_addr_q;
  assign coef_data = coef_data_q;
  assign commit    = commit_q;
  assign busy      = busy_q;
  assign status    = status_q;

endmodule
